// File: rtl/ysyx_22041211_lsu_hs.sv
// Load/store unit with valid/ready handshakes on the EXU, memory and WB sides.
// One op in flight; it is captured in IDLE, issues one bus request if needed, and waits in DONE for WB.
module ysyx_22041211_lsu_hs #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32,
  parameter int STRB_LEN = DATA_LEN / 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                exu_valid_i,
  output logic                lsu_ready_o,
  input  logic                wd_i,
  input  logic [4:0]          wreg_i,
  input  logic [DATA_LEN-1:0] alu_result_i,
  input  logic [DATA_LEN-1:0] mem_wdata_i,
  input  logic [2:0]          load_type_i,
  input  logic [2:0]          store_type_i,
  input  logic [DATA_LEN-1:0] csr_wdata_i,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic                mem_req_wen_o,
  output logic [ADDR_LEN-1:0] mem_req_addr_o,
  output logic [DATA_LEN-1:0] mem_req_wdata_o,
  output logic [STRB_LEN-1:0] mem_req_wstrb_o,
  input  logic                mem_rsp_valid_i,
  input  logic [DATA_LEN-1:0] mem_rsp_rdata_i,
  input  logic                mem_rsp_err_i,
  output logic                lsu_valid_o,
  input  logic                wb_ready_i,
  output logic                wd_o,
  output logic [4:0]          wreg_o,
  output logic [DATA_LEN-1:0] wdata_o,
  output logic [DATA_LEN-1:0] csr_wdata_o,
  output logic                lsu_exc_o,
  output logic [1:0]          lsu_exc_cause_o
);
  localparam int OFF_W = $clog2(STRB_LEN);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  state_e              state_q;
  logic                req_valid_q, req_wen_q, lsu_valid_q;
  logic [ADDR_LEN-1:0] req_addr_q;
  logic [DATA_LEN-1:0] req_wdata_q;
  logic [STRB_LEN-1:0] req_wstrb_q;
  logic                wd_cap_q, wd_q, exc_q;
  logic [4:0]          wreg_q;
  logic [2:0]          ld_type_q;
  logic [OFF_W-1:0]    off_q;
  logic [DATA_LEN-1:0] alu_q, wdata_q, csr_q;
  logic [1:0]          cause_q;

  logic                is_load_d, is_store_d, aligned_d;
  logic [1:0]          size_d;
  logic [ADDR_LEN-1:0] addr_d, req_addr_d;
  logic [OFF_W-1:0]    off_d;
  logic [7:0]          mask8_d;
  logic [STRB_LEN-1:0] wstrb_d;
  logic [DATA_LEN-1:0] req_wdata_d, rsp_shift_d;

  // Sign- or zero-extend the lane-aligned read data according to the load type.
  function automatic logic [DATA_LEN-1:0] load_ext(input logic [2:0] lt,
                                                   input logic [DATA_LEN-1:0] raw);
    logic [DATA_LEN-1:0] r;
    case (lt)
      3'd1:    r = DATA_LEN'($signed(raw[7:0]));
      3'd2:    r = DATA_LEN'($signed(raw[15:0]));
      3'd3:    r = DATA_LEN'($signed(raw[31:0]));
      3'd4:    r = DATA_LEN'(raw[7:0]);
      3'd5:    r = DATA_LEN'(raw[15:0]);
      3'd6:    r = DATA_LEN'(raw[31:0]);
      default: r = raw;
    endcase
    return r;
  endfunction

  // Decode of the incoming op, only consumed on the capture edge.
  always_comb begin
    is_load_d  = 1'b0;
    is_store_d = 1'b0;
    size_d     = 2'd0;
    case (load_type_i)
      3'd1, 3'd4: begin is_load_d = 1'b1; size_d = 2'd0; end
      3'd2, 3'd5: begin is_load_d = 1'b1; size_d = 2'd1; end
      3'd3:       begin is_load_d = 1'b1; size_d = 2'd2; end
      3'd6:       begin is_load_d = (DATA_LEN == 64); size_d = 2'd2; end
      3'd7:       begin is_load_d = (DATA_LEN == 64); size_d = 2'd3; end
      default: ;
    endcase
    if (!is_load_d) begin
      case (store_type_i)
        3'd1:    begin is_store_d = 1'b1; size_d = 2'd0; end
        3'd2:    begin is_store_d = 1'b1; size_d = 2'd1; end
        3'd3:    begin is_store_d = 1'b1; size_d = 2'd2; end
        3'd4:    begin is_store_d = (DATA_LEN == 64); size_d = 2'd3; end
        default: size_d = 2'd0;
      endcase
    end
    addr_d     = ADDR_LEN'(alu_result_i);
    off_d      = addr_d[OFF_W-1:0];
    req_addr_d = {addr_d[ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}};
    case (size_d)
      2'd0:    begin aligned_d = 1'b1;                  mask8_d = 8'h01; end
      2'd1:    begin aligned_d = ~addr_d[0];            mask8_d = 8'h03; end
      2'd2:    begin aligned_d = (addr_d[1:0] == 2'b00); mask8_d = 8'h0F; end
      default: begin aligned_d = (addr_d[2:0] == 3'b000); mask8_d = 8'hFF; end
    endcase
    wstrb_d     = is_store_d ? (mask8_d[STRB_LEN-1:0] << off_d) : '0;
    req_wdata_d = mem_wdata_i << {off_d, 3'b000};
  end

  assign rsp_shift_d = mem_rsp_rdata_i >> {off_q, 3'b000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
      lsu_valid_q <= 1'b0;
      wd_cap_q    <= 1'b0;
      wd_q        <= 1'b0;
      wreg_q      <= '0;
      ld_type_q   <= '0;
      off_q       <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      csr_q       <= '0;
      exc_q       <= 1'b0;
      cause_q     <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: if (exu_valid_i) begin
          wd_cap_q    <= wd_i;
          wreg_q      <= wreg_i;
          csr_q       <= csr_wdata_i;
          alu_q       <= alu_result_i;
          ld_type_q   <= load_type_i;
          off_q       <= off_d;
          req_wen_q   <= is_store_d;
          req_addr_q  <= req_addr_d;
          req_wdata_q <= req_wdata_d;
          req_wstrb_q <= wstrb_d;
          if ((is_load_d || is_store_d) && aligned_d) begin
            state_q     <= S_REQ;
            req_valid_q <= 1'b1;
            wd_q        <= 1'b0;
            exc_q       <= 1'b0;
            cause_q     <= 2'd0;
          end else begin
            // Passthrough and misaligned ops skip the bus entirely.
            state_q     <= S_DONE;
            lsu_valid_q <= 1'b1;
            wdata_q     <= alu_result_i;
            if (is_load_d || is_store_d) begin
              wd_q    <= 1'b0;
              exc_q   <= 1'b1;
              cause_q <= is_load_d ? 2'd1 : 2'd2;
            end else begin
              wd_q    <= wd_i;
              exc_q   <= 1'b0;
              cause_q <= 2'd0;
            end
          end
        end
        S_REQ: if (mem_req_ready_i) begin
          req_valid_q <= 1'b0;
          state_q     <= S_RESP;
        end
        S_RESP: if (mem_rsp_valid_i) begin
          state_q     <= S_DONE;
          lsu_valid_q <= 1'b1;
          wdata_q     <= req_wen_q ? alu_q : load_ext(ld_type_q, rsp_shift_d);
          wd_q        <= wd_cap_q & ~req_wen_q & ~mem_rsp_err_i;
          exc_q       <= mem_rsp_err_i;
          cause_q     <= mem_rsp_err_i ? 2'd3 : 2'd0;
        end
        S_DONE: if (wb_ready_i) begin
          lsu_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign lsu_ready_o     = (state_q == S_IDLE);
  assign mem_req_valid_o = req_valid_q;
  assign mem_req_wen_o   = req_wen_q;
  assign mem_req_addr_o  = req_addr_q;
  assign mem_req_wdata_o = req_wdata_q;
  assign mem_req_wstrb_o = req_wstrb_q;
  assign lsu_valid_o     = lsu_valid_q;
  assign wd_o            = wd_q;
  assign wreg_o          = wreg_q;
  assign wdata_o         = wdata_q;
  assign csr_wdata_o     = csr_q;
  assign lsu_exc_o       = exc_q;
  assign lsu_exc_cause_o = cause_q;

endmodule
